// File: rtl/stack_lifo.sv
// Synchronous LIFO stack with a registered pop-data output and empty/full flags.
// One push or pop per enabled cycle; pushes when full and pops when empty are ignored.
module stack_lifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH + 1)
) (
    input  logic [WIDTH-1:0] data_input,
    output logic [WIDTH-1:0] data_output,
    input  logic             read_write,
    input  logic             enable,
    input  logic             reset,
    output logic             e_flag,
    output logic             f_flag,
    input  logic             clk
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [ADDR_W-1:0] wr_addr, rd_addr;
    logic              push_ok, pop_ok;

    assign e_flag = (cnt_q == '0);
    assign f_flag = (cnt_q == PTR_W'(DEPTH));

    // Low address bits are enough: cnt never exceeds DEPTH, and the top entry
    // wraps correctly to DEPTH-1 when cnt == DEPTH is a power of two.
    assign wr_addr = cnt_q[ADDR_W-1:0];
    assign rd_addr = wr_addr - ADDR_W'(1);

    assign push_ok = enable & ~read_write & ~f_flag;
    assign pop_ok  = enable &  read_write & ~e_flag;

    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        if (push_ok) begin
            cnt_d = cnt_q + PTR_W'(1);
        end else if (pop_ok) begin
            cnt_d  = cnt_q - PTR_W'(1);
            dout_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            dout_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
        end
    end

    // Storage is deliberately left uncleared by reset; only occupancy is discarded.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem_q[wr_addr] <= data_input;
        end
    end

    assign data_output = dout_q;

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: a reference stack generates expected pop
// data into a scoreboard queue, which each scenario task pops and compares.
module tb_stack_lifo;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        read_write = 1'b0;
    logic [15:0] data_input = '0;
    logic [15:0] data_output;
    logic        e_flag, f_flag;

    int checks = 0;
    int errors = 0;

    logic [15:0] model[$];
    logic [15:0] exp_q[$];
    logic [15:0] last_out = '0;

    stack_lifo dut (
        .data_input (data_input),
        .data_output(data_output),
        .read_write (read_write),
        .enable     (enable),
        .reset      (reset),
        .e_flag     (e_flag),
        .f_flag     (f_flag),
        .clk        (clk)
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus, advances the reference stack and queues the
    // expected pop word; outputs are sampled 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic en, input logic rw,
                        input logic [15:0] d, output logic popped);
        reset      = rst;
        enable     = en;
        read_write = rw;
        data_input = d;
        popped     = 1'b0;
        if (rst) begin
            model.delete();
            last_out = '0;
        end else if (en && !rw && model.size() < 8) begin
            model.push_back(d);
        end else if (en && rw && model.size() > 0) begin
            last_out = model.pop_back();
            exp_q.push_back(last_out);
            popped = 1'b1;
        end
        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        logic p;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0000, p);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b1, 16'hBEEF, p);
        checks++; if (data_output !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h expected 0000", data_output); end
        checks++; if (e_flag !== 1'b1) begin errors++; $display("FAIL reset_eflag: got %b expected 1", e_flag); end
        checks++; if (f_flag !== 1'b0) begin errors++; $display("FAIL reset_fflag: got %b expected 0", f_flag); end
    endtask

    task automatic test_push_pop_order();
        logic p;
        logic [15:0] exp;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 16'(2 * i), p);
        checks++; if (e_flag !== 1'b0 || f_flag !== 1'b0) begin errors++; $display("FAIL order_flags_after_push: got e=%b f=%b expected e=0 f=0", e_flag, f_flag); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0000, p);
            checks++;
            if (!p || exp_q.size() == 0) begin errors++; $display("FAIL order_sb_empty: pop %0d produced no expected entry", i); end
            else begin
                exp = exp_q.pop_front();
                if (data_output !== exp || data_output !== 16'(6 - 2 * i)) begin
                    errors++; $display("FAIL order_pop%0d: got %h expected %h", i, data_output, 16'(6 - 2 * i));
                end
            end
        end
        checks++; if (e_flag !== 1'b1) begin errors++; $display("FAIL order_empty_after_pops: got %b expected 1", e_flag); end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0000, p);
            checks++; if (data_output !== 16'h0000 || e_flag !== 1'b1) begin
                errors++; $display("FAIL order_pop_empty%0d: got dout=%h e=%b expected dout=0000 e=1", i, data_output, e_flag);
            end
        end
    endtask

    task automatic test_overflow();
        logic p;
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0011 + 16'(i), p);
            checks++; if (f_flag !== (i == 7)) begin errors++; $display("FAIL fill_fflag%0d: got %b expected %b", i, f_flag, (i == 7)); end
        end
        step(1'b0, 1'b1, 1'b0, 16'hFFFF, p);
        checks++; if (f_flag !== 1'b1 || data_output !== last_out) begin
            errors++; $display("FAIL overflow_push: got f=%b dout=%h expected f=1 dout=%h", f_flag, data_output, last_out);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 16'h0000, p);
            checks++;
            if (!p || exp_q.size() == 0) begin errors++; $display("FAIL overflow_sb_empty: pop %0d produced no expected entry", i); end
            else begin
                exp = exp_q.pop_front();
                if (data_output !== exp || data_output !== 16'h0018 - 16'(i)) begin
                    errors++; $display("FAIL overflow_pop%0d: got %h expected %h", i, data_output, 16'h0018 - 16'(i));
                end
            end
        end
        checks++; if (e_flag !== 1'b1 || f_flag !== 1'b0) begin errors++; $display("FAIL overflow_drained: got e=%b f=%b expected e=1 f=0", e_flag, f_flag); end
    endtask

    task automatic test_enable_gating();
        logic p;
        logic [15:0] exp;
        step(1'b0, 1'b1, 1'b0, 16'h000A, p);
        step(1'b0, 1'b1, 1'b0, 16'h000B, p);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 1'(k), 16'($urandom), p);
            checks++; if (data_output !== last_out || e_flag !== 1'b0 || f_flag !== 1'b0) begin
                errors++; $display("FAIL gating_hold%0d: got dout=%h e=%b f=%b expected dout=%h e=0 f=0", k, data_output, e_flag, f_flag, last_out);
            end
        end
        step(1'b0, 1'b1, 1'b1, 16'h0000, p);
        checks++;
        if (!p || exp_q.size() == 0) begin errors++; $display("FAIL gating_sb_empty: re-enabled pop produced no expected entry"); end
        else begin
            exp = exp_q.pop_front();
            if (data_output !== exp || data_output !== 16'h000B) begin errors++; $display("FAIL gating_pop: got %h expected 000b", data_output); end
        end
        step(1'b0, 1'b1, 1'b1, 16'h0000, p);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++; if (data_output !== 16'h000A || e_flag !== 1'b1) begin errors++; $display("FAIL gating_drain: got dout=%h e=%b expected dout=000a e=1", data_output, e_flag); end
    endtask

    task automatic test_reset_midstream();
        logic p;
        logic [15:0] exp;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 16'h0050 + 16'(i), p);
        step(1'b0, 1'b1, 1'b1, 16'h0000, p);
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        checks++; if (data_output !== 16'h0052) begin errors++; $display("FAIL midreset_prepop: got %h expected 0052", data_output); end
        step(1'b1, 1'b1, 1'b1, 16'h0000, p);
        checks++; if (e_flag !== 1'b1 || data_output !== 16'h0000) begin errors++; $display("FAIL midreset_state: got e=%b dout=%h expected e=1 dout=0000", e_flag, data_output); end
        step(1'b0, 1'b1, 1'b1, 16'h0000, p);
        checks++; if (p || e_flag !== 1'b1 || data_output !== 16'h0000) begin errors++; $display("FAIL midreset_pop_ignored: got e=%b dout=%h expected e=1 dout=0000", e_flag, data_output); end
        step(1'b0, 1'b1, 1'b0, 16'h00AA, p);
        step(1'b0, 1'b1, 1'b1, 16'h0000, p);
        checks++;
        if (!p || exp_q.size() == 0) begin errors++; $display("FAIL midreset_sb_empty: pop after reset produced no expected entry"); end
        else begin
            exp = exp_q.pop_front();
            if (data_output !== exp || data_output !== 16'h00AA) begin errors++; $display("FAIL midreset_pop: got %h expected 00aa", data_output); end
        end
    endtask

    task automatic test_alternating();
        logic p;
        logic [15:0] exp;
        logic [15:0] words [2];
        words[0] = 16'h1234;
        words[1] = 16'h5678;
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, words[i], p);
            checks++; if (e_flag !== 1'b0) begin errors++; $display("FAIL alt_push%0d_eflag: got %b expected 0", i, e_flag); end
            step(1'b0, 1'b1, 1'b1, 16'h0000, p);
            checks++;
            if (!p || exp_q.size() == 0) begin errors++; $display("FAIL alt_sb_empty: pop %0d produced no expected entry", i); end
            else begin
                exp = exp_q.pop_front();
                if (data_output !== exp || data_output !== words[i] || e_flag !== 1'b1) begin
                    errors++; $display("FAIL alt_pop%0d: got dout=%h e=%b expected dout=%h e=1", i, data_output, e_flag, words[i]);
                end
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_push_pop_order();
        test_overflow();
        test_enable_gating();
        test_reset_midstream();
        test_alternating();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
